// File: rtl/seg_display.sv
// seg_display: registered hex-to-seven-segment driver with blanking, lamp test,
// PWM brightness gating and selectable common-anode/common-cathode polarity.
module seg_display #(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter int PWM_BITS   = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [3:0]          i_data,
   input  logic                i_dp,
   input  logic                i_blank,
   input  logic                i_lamp_test,
   input  logic [PWM_BITS-1:0] i_bright,
   output logic [6:0]          o_seg,
   output logic                o_dp
);
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [6:0]          seg_q, seg_d, dec, seg_l;
   logic                dp_q, dp_d, dp_l, en;
   always_comb begin
      case (i_data)
         4'h0: dec = 7'h3F;
         4'h1: dec = 7'h06;
         4'h2: dec = 7'h5B;
         4'h3: dec = 7'h4F;
         4'h4: dec = 7'h66;
         4'h5: dec = 7'h6D;
         4'h6: dec = 7'h7D;
         4'h7: dec = 7'h07;
         4'h8: dec = 7'h7F;
         4'h9: dec = 7'h6F;
         4'hA: dec = 7'h77;
         4'hB: dec = 7'h7C;
         4'hC: dec = 7'h39;
         4'hD: dec = 7'h5E;
         4'hE: dec = 7'h79;
         default: dec = 7'h71;
      endcase
      // all-ones brightness bypasses the counter so full-on is truly 100%
      en    = (&i_bright) | (cnt_q < i_bright);
      seg_l = (i_blank | ~en) ? 7'h00 : i_lamp_test ? 7'h7F : dec;
      dp_l  = (i_blank | ~en) ? 1'b0 : i_lamp_test ? 1'b1 : i_dp;
      seg_d = ACTIVE_LOW ? ~seg_l : seg_l;
      dp_d  = ACTIVE_LOW ? ~dp_l : dp_l;
      cnt_d = cnt_q + PWM_BITS'(1);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         seg_q <= {7{ACTIVE_LOW}};
         dp_q  <= ACTIVE_LOW;
      end else begin
         cnt_q <= cnt_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end
   assign o_seg = seg_q;
   assign o_dp  = dp_q;
endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: directed tests for seg_display, one common-cathode and one
// common-anode instance driven from the same inputs.
module tb_seg_display;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] data = 4'h0;
   logic       dp = 1'b0;
   logic       blank = 1'b0;
   logic       lamp = 1'b0;
   logic [3:0] bright = 4'hF;
   logic [6:0] seg_h, seg_l;
   logic       dp_h, dp_l;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg_display #(.ACTIVE_LOW(1'b0), .PWM_BITS(4)) dut_h (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_blank(blank),
      .i_lamp_test(lamp), .i_bright(bright), .o_seg(seg_h), .o_dp(dp_h));
   seg_display #(.ACTIVE_LOW(1'b1), .PWM_BITS(4)) dut_l (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_blank(blank),
      .i_lamp_test(lamp), .i_bright(bright), .o_seg(seg_l), .o_dp(dp_l));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      n_chk++;
      if (seg_h !== 7'h00 || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_high seg=%h dp=%b expected seg=00 dp=0", seg_h, dp_h);
      end
      n_chk++;
      if (seg_l !== 7'h7F || dp_l !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_low seg=%h dp=%b expected seg=7F dp=1", seg_l, dp_l);
      end
      data = 4'h8; lamp = 1'b1; bright = 4'hF; rst = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h7F || dp_h !== 1'b1) begin
         n_fail++;
         $display("FAIL lamp_pre_reset seg=%h dp=%b expected seg=7F dp=1", seg_h, dp_h);
      end
      rst = 1'b1;
      step();
      n_chk++;
      if (seg_h !== 7'h00 || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset seg=%h dp=%b expected seg=00 dp=0", seg_h, dp_h);
      end
      rst = 1'b0; lamp = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h7F || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL resume seg=%h dp=%b expected seg=7F dp=0", seg_h, dp_h);
      end
   endtask

   task automatic test_decode();
      bright = 4'hF; blank = 1'b0; lamp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         data = 4'(i);
         dp = 1'((i / 2) % 2);
         for (int c = 0; c < 2; c++) begin
            step();
            n_chk++;
            if (seg_h !== tbl[i] || dp_h !== dp) begin
               n_fail++;
               $display("FAIL decode_%0d seg=%h dp=%b expected seg=%h dp=%b", i, seg_h, dp_h, tbl[i], dp);
            end
            n_chk++;
            if (seg_l !== ~tbl[i] || dp_l !== ~dp) begin
               n_fail++;
               $display("FAIL decode_low_%0d seg=%h dp=%b expected seg=%h dp=%b", i, seg_l, dp_l, ~tbl[i], ~dp);
            end
         end
      end
   endtask

   task automatic test_priority();
      bright = 4'hF; data = 4'h2; dp = 1'b0;
      blank = 1'b1; lamp = 1'b1;
      step();
      n_chk++;
      if (seg_h !== 7'h00 || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL blank_wins seg=%h dp=%b expected seg=00 dp=0", seg_h, dp_h);
      end
      blank = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h7F || dp_h !== 1'b1) begin
         n_fail++;
         $display("FAIL lamp_test seg=%h dp=%b expected seg=7F dp=1", seg_h, dp_h);
      end
      lamp = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h5B || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL normal_2 seg=%h dp=%b expected seg=5B dp=0", seg_h, dp_h);
      end
   endtask

   task automatic test_polarity();
      bright = 4'hF; data = 4'h0; dp = 1'b1; blank = 1'b0; lamp = 1'b0;
      step();
      n_chk++;
      if (seg_l !== 7'h40 || dp_l !== 1'b0) begin
         n_fail++;
         $display("FAIL polarity seg=%h dp=%b expected seg=40 dp=0", seg_l, dp_l);
      end
      blank = 1'b1;
      step();
      n_chk++;
      if (seg_l !== 7'h7F || dp_l !== 1'b1) begin
         n_fail++;
         $display("FAIL polarity_blank seg=%h dp=%b expected seg=7F dp=1", seg_l, dp_l);
      end
      blank = 1'b0;
   endtask

   task automatic test_pwm();
      int lit, dark;
      data = 4'h8; dp = 1'b0; blank = 1'b0; lamp = 1'b0;
      bright = 4'h4; lit = 0; dark = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (seg_h === 7'h7F) lit++;
         else if (seg_h === 7'h00) dark++;
      end
      n_chk++;
      if (lit !== 4 || dark !== 12) begin
         n_fail++;
         $display("FAIL pwm_4 lit=%0d dark=%0d expected lit=4 dark=12", lit, dark);
      end
      bright = 4'h0; lit = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (seg_h !== 7'h00) lit++;
      end
      n_chk++;
      if (lit !== 0) begin
         n_fail++;
         $display("FAIL pwm_0 lit=%0d expected lit=0", lit);
      end
      bright = 4'hF; dark = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (seg_h !== 7'h7F) dark++;
      end
      n_chk++;
      if (dark !== 0) begin
         n_fail++;
         $display("FAIL pwm_F dark=%0d expected dark=0", dark);
      end
   endtask

   task automatic test_wrap();
      int lit, first, second;
      data = 4'h8; bright = 4'h1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h7F) begin
         n_fail++;
         $display("FAIL first_after_reset seg=%h expected seg=7F", seg_h);
      end
      step();
      n_chk++;
      if (seg_h !== 7'h00) begin
         n_fail++;
         $display("FAIL second_after_reset seg=%h expected seg=00", seg_h);
      end
      lit = 0; first = -1; second = -1;
      for (int c = 0; c < 32; c++) begin
         step();
         if (seg_h === 7'h7F) begin
            lit++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      n_chk++;
      if (lit !== 2) begin
         n_fail++;
         $display("FAIL wrap_count lit=%0d expected lit=2", lit);
      end
      n_chk++;
      if (second - first !== 16) begin
         n_fail++;
         $display("FAIL wrap_period period=%0d expected period=16", second - first);
      end
   endtask

   task automatic test_back_to_back();
      bright = 4'hF; blank = 1'b0; lamp = 1'b0;
      data = 4'hA; dp = 1'b1;
      step();
      n_chk++;
      if (seg_h !== 7'h77 || dp_h !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_A seg=%h dp=%b expected seg=77 dp=1", seg_h, dp_h);
      end
      data = 4'hD; dp = 1'b0;
      step();
      n_chk++;
      if (seg_h !== 7'h5E || dp_h !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_d seg=%h dp=%b expected seg=5E dp=0", seg_h, dp_h);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_priority();
      test_polarity();
      test_pwm();
      test_wrap();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seg_display.md
# seg_display

Single-digit seven-segment display driver. Decodes a 4-bit hexadecimal value (0–F) and a decimal-point request into segment drive signals. Outputs are registered, with blanking, lamp-test and PWM brightness control. Sits between the numeric datapath and the board's seven-segment digit pins; one instance per digit.

## Interface
- ACTIVE_LOW, default 0: 0 = segment lit when driven 1 (common cathode); 1 = all of o_seg/o_dp inverted (common anode).
- PWM_BITS, default 4: width of the brightness control and internal PWM counter; legal range 1–8.

- i_clk  input  1  system clock; one clock domain, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  4  hex digit to display, 0x0–0xF.
- i_dp  input  1  1 = light decimal point.
- i_blank  input  1  1 = all segments and DP off.
- i_lamp_test  input  1  1 = all seven segments and DP lit.
- i_bright  input  PWM_BITS  brightness; all-ones = full on.
- o_seg  output  7  segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- o_dp  output  1  decimal-point drive.

## Operation
- Logical (active-high) patterns, {g,f,e,d,c,b,a} in hex:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- Logical DP = i_dp.
- Selection priority, highest first:
  - i_blank=1 → seg=00, dp=0.
  - i_lamp_test=1 → seg=7F, dp=1.
  - Otherwise → decoded pattern and i_dp.
- PWM gate:
  - Free-running PWM_BITS counter cnt; increments every cycle, wraps from all-ones to 0.
  - Phase enable en = (i_bright == all-ones) | (cnt < i_bright).
  - When en=0, logical seg=00 and dp=0.
  - Duty = i_bright/2^PWM_BITS, except all-ones = 100%; i_bright=0 = always off.
- Polarity: if ACTIVE_LOW=1, invert the final logical values bitwise before the output registers.
- All inputs are sampled each cycle; no handshake, no internal state besides cnt and the output registers.

## Timing
- o_seg/o_dp are registered: a change on i_data, i_dp, i_blank, i_lamp_test or i_bright appears on the outputs on the next rising edge (1-cycle latency).
- Reset value, held for every edge with i_rst=1:
  - ACTIVE_LOW=0: o_seg=7'h00, o_dp=0.
  - ACTIVE_LOW=1: o_seg=7'h7F, o_dp=1.
  - cnt=0.
- First edge after reset deasserts: cnt=0 is in effect, so a non-zero i_bright gives an on phase.
- Reset asserted mid-operation: outputs go to the off state and cnt clears on that same edge; no decoded value survives.
- Inputs change freely every cycle; each edge reflects only the values sampled at that edge.
- Simultaneous i_blank and i_lamp_test: blank wins.

## Test plan
- Decode sweep: ACTIVE_LOW=0, i_bright=all-ones, i_data stepped 0→F one value per 2 cycles, i_dp toggled every 4 cycles → o_seg matches the table one cycle after each change (e.g. 8→7F, b→7C); o_dp follows i_dp one cycle late.
- Reset: drive i_data=8, i_lamp_test=1, then assert i_rst for 1 cycle → o_seg=00 and o_dp=0 on that edge; decoded output resumes one cycle after deassert.
- Priority: i_blank=1 with i_lamp_test=1 → seg=00, dp=0; i_blank=0 → seg=7F, dp=1; both 0 with i_data=2 → seg=5B.
- Polarity: ACTIVE_LOW=1, i_data=0, i_dp=1 → o_seg=40, o_dp=0; during reset → o_seg=7F, o_dp=1.
- PWM: PWM_BITS=4, i_bright=4, i_data=8 → over 16 consecutive cycles o_seg=7F for exactly 4 cycles and 00 for 12; i_bright=0 → always 00; i_bright=F → always 7F.
- Wrap: hold i_bright=1 for 32 cycles → exactly one lit cycle per 16, period exactly 16.
